// File: rtl/calc_entry_seq.sv
// calc_entry_seq
//   Operand-entry front end for the hex calculator. Two bouncy active-low
//   pushbuttons (enter, clear) are synchronized and debounced. Successive
//   enter presses capture operand A, operand B and the operation from the
//   value switches. The completed request is then offered to the datapath
//   through a valid/ready handshake.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   sw        : value switches (quasi-static, sampled only on capture edges)
//   enter_n   : enter pushbutton, active-low, asynchronous
//   clear_n   : clear pushbutton, active-low, asynchronous
//   a_val     : captured operand A
//   b_val     : captured operand B
//   op        : captured operation (00 add, 01 sub, 10 mul, 11 div)
//   op_valid  : request valid (high in ISSUE)
//   op_ready  : request accepted by the datapath
//   stage     : one-hot entry step (001 A, 010 B, 100 op, 000 otherwise)
module calc_entry_seq #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       enter_n,
  input  logic       clear_n,
  output logic [3:0] a_val,
  output logic [3:0] b_val,
  output logic [1:0] op,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [2:0] stage
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    SHOW   = 3'd4
  } state_t;

  // Key index 0 = enter, 1 = clear.
  logic [1:0]       key_n;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       prev_q;
  logic [1:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic enter_p, clear_p;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] op_q, op_d;

  assign key_n = {clear_n, enter_n};

  // Debounce: the counter runs only while the synchronized level disagrees
  // with the accepted level, and the new level is accepted once it has
  // disagreed for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          stable_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end
    end
  end

  // Registered press pulse: accepted level went 1 -> 0 on the previous edge.
  assign press_d = prev_q & ~stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      stable_q <= 2'b11;
      prev_q   <= 2'b11;
      press_q  <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      press_q  <= press_d;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign enter_p = press_q[0];
  assign clear_p = press_q[1];

  // Entry FSM. Clear is checked first so it wins over a coincident enter.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    if (clear_p) begin
      state_d = GET_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else begin
      case (state_q)
        GET_A: begin
          if (enter_p) begin
            a_d     = sw;
            state_d = GET_B;
          end
        end
        GET_B: begin
          if (enter_p) begin
            b_d     = sw;
            state_d = GET_OP;
          end
        end
        GET_OP: begin
          if (enter_p) begin
            op_d    = sw[1:0];
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (op_ready) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          // Operands stay on display; the next A is taken on the following press.
          if (enter_p) begin
            state_d = GET_A;
          end
        end
        default: state_d = GET_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    stage = 3'b000;
    case (state_q)
      GET_A:   stage = 3'b001;
      GET_B:   stage = 3'b010;
      GET_OP:  stage = 3'b100;
      default: stage = 3'b000;
    endcase
  end

  assign op_valid = (state_q == ISSUE);
  assign a_val    = a_q;
  assign b_val    = b_q;
  assign op       = op_q;

endmodule

// File: tb/tb_calc_entry_seq.sv
module tb_calc_entry_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       enter_n;
  logic       clear_n;
  logic [3:0] a_val;
  logic [3:0] b_val;
  logic [1:0] op;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] stage;

  int n_checks;
  int n_errors;

  calc_entry_seq #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .enter_n (enter_n),
    .clear_n (clear_n),
    .a_val   (a_val),
    .b_val   (b_val),
    .op      (op),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .stage   (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press enter with value v. The first edge after the drive samples the
  // falling edge (edge t); the capture lands on edge t+7, i.e. after the
  // eighth tick, so the stage must still be unchanged after the seventh.
  task automatic press_enter(input string tag, input logic [3:0] v,
                             input logic [31:0] stg_before, input logic [31:0] stg_after);
    sw      = v;
    enter_n = 1'b0;
    repeat (7) tick();
    chk({tag, "_stage_hold"}, 32'(stage), stg_before);
    tick();
    chk({tag, "_stage_step"}, 32'(stage), stg_after);
  endtask

  task automatic release_keys();
    enter_n = 1'b1;
    clear_n = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    sw       = 4'h0;
    enter_n  = 1'b1;
    clear_n  = 1'b1;
    op_ready = 1'b1;

    // Reset values, before any clock edge
    #3;
    chk("rst_stage", 32'(stage), 32'h1);
    chk("rst_valid", 32'(op_valid), 32'h0);
    chk("rst_a", 32'(a_val), 32'h0);
    chk("rst_b", 32'(b_val), 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Full entry with op_ready tied high: 9, 3, 6 (op = 10)
    press_enter("a9", 4'h9, 32'h1, 32'h2);
    chk("a9_a", 32'(a_val), 32'h9);
    release_keys();
    press_enter("b3", 4'h3, 32'h2, 32'h4);
    chk("b3_b", 32'(b_val), 32'h3);
    chk("b3_a", 32'(a_val), 32'h9);
    release_keys();
    press_enter("op6", 4'h6, 32'h4, 32'h0);
    chk("op6_op", 32'(op), 32'h2);
    chk("op6_valid_hi", 32'(op_valid), 32'h1);
    tick();
    chk("op6_valid_lo", 32'(op_valid), 32'h0);
    chk("show_stage", 32'(stage), 32'h0);
    release_keys();
    chk("show_a", 32'(a_val), 32'h9);
    chk("show_b", 32'(b_val), 32'h3);
    chk("show_op", 32'(op), 32'h2);

    // Wrap-around: SHOW -> GET_A without capture, then A = F
    press_enter("wrap", 4'hA, 32'h0, 32'h1);
    chk("wrap_a_hold", 32'(a_val), 32'h9);
    chk("wrap_b_hold", 32'(b_val), 32'h3);
    release_keys();
    press_enter("aF", 4'hF, 32'h1, 32'h2);
    chk("aF_a", 32'(a_val), 32'hF);
    release_keys();

    // Bounce rejection in GET_B: low pulses of 1, 2, 3 cycles
    sw = 4'h5;
    for (int w = 1; w <= 3; w++) begin
      enter_n = 1'b0;
      repeat (w) tick();
      enter_n = 1'b1;
      repeat (4) tick();
    end
    chk("bounce_stage", 32'(stage), 32'h2);
    chk("bounce_b", 32'(b_val), 32'h3);
    enter_n = 1'b0;
    repeat (20) tick();
    chk("hold_stage", 32'(stage), 32'h4);
    chk("hold_b", 32'(b_val), 32'h5);
    release_keys();
    chk("hold_rel_stage", 32'(stage), 32'h4);
    chk("hold_rel_op", 32'(op), 32'h2);

    // Backpressure: op_ready low when ISSUE is entered (op = 01)
    op_ready = 1'b0;
    press_enter("opD", 4'hD, 32'h4, 32'h0);
    chk("bp_valid0", 32'(op_valid), 32'h1);
    chk("bp_op", 32'(op), 32'h1);
    release_keys();
    press_enter("bp_ign", 4'h0, 32'h0, 32'h0);
    release_keys();
    chk("bp_valid1", 32'(op_valid), 32'h1);
    chk("bp_a", 32'(a_val), 32'hF);
    chk("bp_b", 32'(b_val), 32'h5);
    chk("bp_op_hold", 32'(op), 32'h1);
    op_ready = 1'b1;
    #1;
    chk("bp_valid_pre", 32'(op_valid), 32'h1);
    tick();
    chk("bp_valid_drop", 32'(op_valid), 32'h0);
    chk("bp_show_stage", 32'(stage), 32'h0);
    press_enter("bp_show", 4'h0, 32'h0, 32'h1);
    release_keys();

    // Clear priority over a coincident enter in GET_B
    press_enter("a7", 4'h7, 32'h1, 32'h2);
    chk("a7_a", 32'(a_val), 32'h7);
    release_keys();
    sw      = 4'hC;
    enter_n = 1'b0;
    clear_n = 1'b0;
    repeat (8) tick();
    chk("clr_stage", 32'(stage), 32'h1);
    chk("clr_a", 32'(a_val), 32'h0);
    chk("clr_b", 32'(b_val), 32'h0);
    chk("clr_op", 32'(op), 32'h0);
    release_keys();
    chk("clr_rel_stage", 32'(stage), 32'h1);

    // Asynchronous reset during a stalled ISSUE
    op_ready = 1'b0;
    press_enter("r_a", 4'h1, 32'h1, 32'h2);
    release_keys();
    press_enter("r_b", 4'h2, 32'h2, 32'h4);
    release_keys();
    press_enter("r_op", 4'h3, 32'h4, 32'h0);
    chk("r_valid", 32'(op_valid), 32'h1);
    chk("r_op_val", 32'(op), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_stage", 32'(stage), 32'h1);
    chk("ar_valid", 32'(op_valid), 32'h0);
    chk("ar_a", 32'(a_val), 32'h0);
    chk("ar_b", 32'(b_val), 32'h0);
    chk("ar_op", 32'(op), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
